// File: rtl/tensorflowe_dot_engine.sv
// -----------------------------------------------------------------------------
// tensorflowe_dot_engine
//
// Byte-serial dot-product engine. A weight vector and an activation vector are
// streamed in one element per ena_write strobe (weights first, then
// activations). enable_accu then runs a signed multiply-accumulate over the
// vector, one element per cycle, into a persistent saturating accumulator.
// A read request in DONE returns the requantised accumulator (arithmetic
// shift, clamp to DATA_W, optional ReLU) with a one-cycle valid.
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   datos_in        signed element being written
//   ena_write       store datos_in at the write pointer (IDLE, not full)
//   enable_accu     start the MAC pass (IDLE with a full buffer)
//   ena_read        request the result (DONE only)
//   clear           zero accumulator and write pointer, return to IDLE
//   relu_en         1 = negative results are returned as 0
//   datos_out       requantised result (holds until the next read or rst)
//   ena_out         one-cycle valid for datos_out
//   busy            high while the MAC pass runs
//   dato_disponible high while a result is waiting to be read
// -----------------------------------------------------------------------------
module tensorflowe_dot_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 20,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] datos_in,
    input  logic              ena_write,
    input  logic              enable_accu,
    input  logic              ena_read,
    input  logic              clear,
    input  logic              relu_en,
    output logic [DATA_W-1:0] datos_out,
    output logic              ena_out,
    output logic              busy,
    output logic              dato_disponible
);

    localparam int WP_W  = $clog2(2 * DEPTH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [WP_W-1:0]  WP_LAST  = WP_W'(2 * DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    // Output range expressed at accumulator width so the clamp compares
    // like with like; ~Q_MAX is exactly -2^(DATA_W-1).
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [WP_W-1:0]           wp_q, wp_d;
    logic                      full_q, full_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]         dout_q, dout_d;
    logic                      ena_out_q, ena_out_d;

    logic signed [DATA_W-1:0]  w_mem [DEPTH];
    logic signed [DATA_W-1:0]  a_mem [DEPTH];

    logic                      wr_en;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W:0]     sum;
    logic signed [ACC_W-1:0]   acc_sat;
    logic signed [ACC_W-1:0]   shifted;
    logic [DATA_W-1:0]         q_val;

    // A write lands only when the engine is idle, the buffer is not yet
    // full and no clear is taking priority this cycle.
    assign wr_en = ena_write && (state_q == S_IDLE) && !full_q && !clear;

    // Element buffers: pointer 0..DEPTH-1 selects weights, DEPTH..2*DEPTH-1
    // selects activations. Contents are don't-care after reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (wr_en && (wp_q == WP_W'(gi))) begin
                    w_mem[gi] <= datos_in;
                end
                if (wr_en && (wp_q == WP_W'(DEPTH + gi))) begin
                    a_mem[gi] <= datos_in;
                end
            end
        end
    endgenerate

    // Full-precision signed MAC with one guard bit for overflow detection.
    assign prod = w_mem[idx_q] * a_mem[idx_q];
    assign sum  = {acc_q[ACC_W-1], acc_q}
                + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};

    always_comb begin
        acc_sat = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Requantisation: floor shift, clamp to the output range, then ReLU.
    assign shifted = acc_q >>> SHIFT;

    always_comb begin
        q_val = shifted[DATA_W-1:0];
        if (shifted > Q_MAX) begin
            q_val = Q_MAX[DATA_W-1:0];
        end else if (shifted < Q_MIN) begin
            q_val = Q_MIN[DATA_W-1:0];
        end
        if (relu_en && (shifted < 0)) begin
            q_val = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        full_d    = full_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        dout_d    = dout_q;
        ena_out_d = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            wp_d    = '0;
            full_d  = 1'b0;
            idx_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ena_write && !full_q) begin
                        if (wp_q == WP_LAST) begin
                            full_d = 1'b1;
                        end else begin
                            wp_d = wp_q + 1'b1;
                        end
                    end
                    // Uses the registered flag, so a start in the same
                    // cycle as the final write is not accepted.
                    if (enable_accu && full_q) begin
                        state_d = S_COMPUTE;
                        idx_d   = '0;
                    end
                end
                S_COMPUTE: begin
                    acc_d = acc_sat;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (ena_read) begin
                        dout_d    = q_val;
                        ena_out_d = 1'b1;
                        state_d   = S_IDLE;
                        wp_d      = '0;
                        full_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wp_q      <= '0;
            full_q    <= 1'b0;
            idx_q     <= '0;
            acc_q     <= '0;
            dout_q    <= '0;
            ena_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            full_q    <= full_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            dout_q    <= dout_d;
            ena_out_q <= ena_out_d;
        end
    end

    assign datos_out       = dout_q;
    assign ena_out         = ena_out_q;
    assign busy            = (state_q == S_COMPUTE);
    assign dato_disponible = (state_q == S_DONE);

endmodule

// File: tb/tb_tensorflowe_dot_engine.sv
// -----------------------------------------------------------------------------
// tb_tensorflowe_dot_engine
//
// Directed bench. Three engines share one stimulus stream:
//   dut_a  default parameters
//   dut_b  SHIFT=2
//   dut_c  ACC_W=18, SHIFT=10 (narrow accumulator so saturation is visible
//          at the output)
// Expected results are hand-computed per vector.
// -----------------------------------------------------------------------------
module tb_tensorflowe_dot_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] datos_in;
    logic       ena_write;
    logic       enable_accu;
    logic       ena_read;
    logic       clear;
    logic       relu_en;

    logic [7:0] a_out, b_out, c_out;
    logic       a_ena, b_ena, c_ena;
    logic       a_busy, b_busy, c_busy;
    logic       a_dd, b_dd, c_dd;

    int n_checks = 0;
    int n_fail   = 0;

    // Vectors packed element 0 in the low byte.
    localparam logic [31:0] W_SEQ    = 32'h04030201; // 1,2,3,4
    localparam logic [31:0] ONES     = 32'h01010101;
    localparam logic [31:0] ALL_127  = 32'h7F7F7F7F;
    localparam logic [31:0] ALL_M128 = 32'h80808080;
    localparam logic [31:0] W_NEG    = 32'hFCFDFEFF; // -1,-2,-3,-4

    always #5 clk = ~clk;

    tensorflowe_dot_engine dut_a (
        .clk(clk), .rst(rst), .datos_in(datos_in), .ena_write(ena_write),
        .enable_accu(enable_accu), .ena_read(ena_read), .clear(clear),
        .relu_en(relu_en), .datos_out(a_out), .ena_out(a_ena),
        .busy(a_busy), .dato_disponible(a_dd)
    );

    tensorflowe_dot_engine #(.SHIFT(2)) dut_b (
        .clk(clk), .rst(rst), .datos_in(datos_in), .ena_write(ena_write),
        .enable_accu(enable_accu), .ena_read(ena_read), .clear(clear),
        .relu_en(relu_en), .datos_out(b_out), .ena_out(b_ena),
        .busy(b_busy), .dato_disponible(b_dd)
    );

    tensorflowe_dot_engine #(.ACC_W(18), .SHIFT(10)) dut_c (
        .clk(clk), .rst(rst), .datos_in(datos_in), .ena_write(ena_write),
        .enable_accu(enable_accu), .ena_read(ena_read), .clear(clear),
        .relu_en(relu_en), .datos_out(c_out), .ena_out(c_ena),
        .busy(c_busy), .dato_disponible(c_dd)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input logic [7:0] v);
        datos_in  = v;
        ena_write = 1'b1;
        tick();
        ena_write = 1'b0;
    endtask

    task automatic load(input logic [31:0] wv, input logic [31:0] av);
        for (int i = 0; i < 4; i++) write_elem(wv[8*i +: 8]);
        for (int i = 0; i < 4; i++) write_elem(av[8*i +: 8]);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Start, verify COMPUTE/DONE timing, read and verify result and valid.
    task automatic run_read(input string tag, input logic relu, input int exp_a,
                            input bit chk_b, input int exp_b,
                            input bit chk_c, input int exp_c);
        enable_accu = 1'b1;
        tick();
        enable_accu = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq({tag, "_busy"}, int'(a_busy), 1);
            tick();
        end
        check_eq({tag, "_busy_end"}, int'(a_busy), 0);
        check_eq({tag, "_dd"}, int'(a_dd), 1);
        relu_en  = relu;
        ena_read = 1'b1;
        tick();
        ena_read = 1'b0;
        relu_en  = 1'b0;
        check_eq({tag, "_ena"}, int'(a_ena), 1);
        check_eq({tag, "_a"}, int'($signed(a_out)), exp_a);
        if (chk_b) check_eq({tag, "_b"}, int'($signed(b_out)), exp_b);
        if (chk_c) check_eq({tag, "_c"}, int'($signed(c_out)), exp_c);
        $display("read %s: a=%0d b=%0d c=%0d", tag, $signed(a_out),
                 $signed(b_out), $signed(c_out));
        tick();
        check_eq({tag, "_ena_pulse"}, int'(a_ena), 0);
        check_eq({tag, "_dd_clr"}, int'(a_dd), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; datos_in = '0; ena_write = 1'b0; enable_accu = 1'b0;
        ena_read = 1'b0; clear = 1'b0; relu_en = 1'b0;
        tick(); tick();
        check_eq("rst_out", int'(a_out), 0);
        check_eq("rst_ena", int'(a_ena), 0);
        check_eq("rst_busy", int'(a_busy), 0);
        check_eq("rst_dd", int'(a_dd), 0);
        rst = 1'b0;
        tick();

        // Basic dot product: 1+2+3+4.
        load(W_SEQ, ONES);
        run_read("s1", 1'b0, 10, 1, 2, 1, 0);

        // Accumulates without clear, then restarts after clear.
        load(W_SEQ, ONES);
        run_read("s3_acc", 1'b0, 20, 1, 5, 0, 0);
        pulse_clear();
        load(W_SEQ, ONES);
        run_read("s3_clr", 1'b0, 10, 1, 2, 0, 0);

        // Positive clamp; dut_c accumulator saturates on the 3rd pass.
        pulse_clear();
        load(ALL_127, ALL_127);
        run_read("s2_pos1", 1'b0, 127, 0, 0, 1, 63);
        load(ALL_127, ALL_127);
        run_read("s2_pos2", 1'b0, 127, 0, 0, 1, 126);
        load(ALL_127, ALL_127);
        run_read("s2_pos3", 1'b0, 127, 0, 0, 1, 127);

        // Negative clamp and ReLU.
        pulse_clear();
        load(ALL_M128, ONES);
        run_read("s2_neg", 1'b0, -128, 1, -128, 1, -1);
        pulse_clear();
        load(ALL_M128, ONES);
        run_read("s2_relu", 1'b1, 0, 1, 0, 1, 0);

        // Negative saturation on the narrow accumulator.
        pulse_clear();
        load(ALL_M128, ALL_127);
        run_read("sat_neg1", 1'b0, -128, 0, 0, 1, -64);
        load(ALL_M128, ALL_127);
        run_read("sat_neg2", 1'b0, -128, 0, 0, 1, -127);
        load(ALL_M128, ALL_127);
        run_read("sat_neg3", 1'b0, -128, 0, 0, 1, -128);

        // Floor shift of a negative sum: -10 >>> 2 = -3.
        pulse_clear();
        load(W_NEG, ONES);
        run_read("s6_neg", 1'b0, -10, 1, -3, 1, -1);

        // Ignored operations.
        pulse_clear();
        for (int i = 0; i < 4; i++) write_elem(W_SEQ[8*i +: 8]);
        for (int i = 0; i < 3; i++) write_elem(8'd1);
        enable_accu = 1'b1;
        tick();
        enable_accu = 1'b0;
        check_eq("s4_start7_busy", int'(a_busy), 0);
        datos_in    = 8'd1;
        ena_write   = 1'b1;
        enable_accu = 1'b1;
        tick();
        ena_write   = 1'b0;
        enable_accu = 1'b0;
        check_eq("s4_start8_busy", int'(a_busy), 0);
        check_eq("s4_start8_dd", int'(a_dd), 0);
        write_elem(8'd100);
        ena_read = 1'b1;
        tick();
        ena_read = 1'b0;
        check_eq("s4_read_idle", int'(a_ena), 0);
        run_read("s4_9th", 1'b0, 10, 1, 2, 0, 0);

        // Reset in the 2nd COMPUTE cycle (acc holds 10 beforehand).
        load(W_SEQ, ONES);
        enable_accu = 1'b1;
        tick();
        enable_accu = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("s5_busy", int'(a_busy), 0);
        check_eq("s5_out", int'(a_out), 0);
        check_eq("s5_dd", int'(a_dd), 0);
        load(W_SEQ, ONES);
        run_read("s5_after", 1'b0, 10, 1, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
